inst_mem_loader: RTL

Boot-time program loader for the 16-word instruction memory. Accepts a byte stream from the host link (UART receiver or debug port) and packs bytes little-endian into 32-bit words. Writes each word through the memory's write port (`en_addr_inst`/`addr_inst`/`data_inst`) and holds the CPU core in reset until the full image is in place. Sits between the host-link receiver and the instruction memory, alongside the CPU top level.

---
 rtl/inst_mem_loader_pkg.sv | 13 +
 rtl/inst_mem_loader_if.sv | 18 +
 rtl/inst_mem_loader_byte_packer.sv | 27 ++
 rtl/inst_mem_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package inst_loader_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam int WORDS  = 16;
  localparam int ADDR_W = 6;
endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake from the host-link receiver into the loader.
interface inst_mem_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Little-endian 4-byte assembler: three bytes are kept, the fourth
// is merged combinationally so the word is ready on its accept cycle.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  din,
  input  logic [1:0]  idx,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (clr) begin
      shift_q <= '0;
    end else if (take) begin
      shift_q <= {din, shift_q[23:8]};
    end
  end

  assign word      = {din, shift_q};
  assign word_done = take && (idx == 2'd3);
endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: packs host bytes into words, writes instruction memory.
// Optional image checksum enabled by INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int WORDS  = inst_loader_pkg::WORDS,
  parameter int ADDR_W = inst_loader_pkg::ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_arstn,
  input  logic              start,
  inst_mem_loader_if.slave  rx,
  output logic              en_addr_inst,
  output logic [ADDR_W-1:0] addr_inst,
  output logic [31:0]       data_inst,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import inst_loader_pkg::*;

  localparam int CW = $clog2(WORDS * 4);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic          take;
  logic          load_take;
  logic          clr;
  logic          last;
  logic [31:0]   word;
  logic          word_done;

  assign rx.rx_ready = (state_q == LOAD) || (state_q == CHK);
  assign busy        = rx.rx_ready;
  assign done        = (state_q == DONE);
  assign take        = rx.rx_valid && rx.rx_ready;
  assign load_take   = take && (state_q == LOAD);
  assign last        = (cnt_q == {CW{1'b1}});
  assign clr         = start && (state_q == IDLE ||
                                 state_q == DONE ||
                                 state_q == ERR);

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (load_take) begin
      sum_q <= sum_q + rx.rx_data;
    end
  end

  assign err = (state_q == ERR);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (load_take && last) state_d = CHK;
`else
        if (load_take && last) state_d = DONE;
`endif
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK: begin
        if (take) state_d = (rx.rx_data == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr) cnt_q <= '0;
      else if (load_take) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Released only once DONE is already the present state, so the final
  // memory write lands a cycle before the core leaves reset.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      cpu_rstn <= 1'b0;
    end else begin
      cpu_rstn <= (state_q == DONE) && (state_d == DONE);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      en_addr_inst <= 1'b0;
      addr_inst    <= '0;
      data_inst    <= '0;
    end else begin
      en_addr_inst <= word_done;
      if (word_done) begin
        addr_inst <= ADDR_W'({cnt_q[CW-1:2], 2'b00});
        data_inst <= word;
      end
    end
  end

  byte_packer u_packer (
    .clk       (sys_clk),
    .rst_n     (sys_arstn),
    .clr       (clr),
    .take      (load_take),
    .din       (rx.rx_data),
    .idx       (cnt_q[1:0]),
    .word      (word),
    .word_done (word_done)
  );
endmodule
